pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-flow controller for the 9-bit core.
- Owns the program counter, the start/done handshake with the test harness, and the zero/negative condition-flag registers.
- Consumes the decoder's branch controls and resolves each instruction's next PC.
- Sits between the control decoder/ALU and instruction memory; gates architectural writes through Run.

Parameters:
PC_W, 10, program counter width in bits
LAST_ADDR, 1023, address of the final instruction; executing it ends the program
CNT_W, 16, width of the saturating cycle counter

Ports:
Clk  input  1  clock; all state updates on the rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  harness request; a high level arms, the falling edge launches execution
Halt  input  1  current instruction is the halt encoding
AbsBranch  input  1  decoder: absolute branch
RelBranch  input  1  decoder: relative branch
BranchFlag  input  1  decoder: flag to test; 0 = zero, 1 = negative
BranchInvert  input  1  decoder: invert the tested flag
AbsTarget  input  PC_W  absolute target, zero-extended operand
RelOffset  input  6  signed relative offset, two's complement
FlagWrite  input  1  latch ALU flags this cycle (decoder RegWrite)
AluZero  input  1  ALU result == 0
AluNeg  input  1  ALU result[7]
PC  output  PC_W  current instruction address to instruction memory
Run  output  1  write enable qualifier for register file and data memory
Done  output  1  program finished
ZeroFlag  output  1  registered zero flag
NegFlag  output  1  registered negative flag
CycleCount  output  CNT_W  RUN cycles since the last launch

Behaviour:
- Reset, taken on any cycle including mid-RUN:
  - state = IDLE, PC = 0, Done = 0.
  - ZeroFlag = 0, NegFlag = 0, CycleCount = 0.
  - Run = 0 from the following cycle.
- State machine, 2-bit encoding: IDLE, ARM, RUN, DONE.
  - IDLE: Start = 1 -> ARM; otherwise stay.
  - ARM:
    - PC held at 0; flags and CycleCount cleared; Done = 0.
    - Start = 0 -> RUN, so the first instruction issues the cycle after the falling edge.
  - RUN: one instruction per cycle.
    - Halt = 1 -> DONE. PC is not advanced and the flags are not updated.
    - PC == LAST_ADDR with Halt = 0 -> the instruction completes (flags and writes proceed); next state DONE; PC frozen at LAST_ADDR.
    - Start = 1 is ignored.
  - DONE:
    - Done = 1 registered, asserted the cycle after the exit condition.
    - PC and flags hold.
    - Start = 1 -> ARM; Done drops on entry to ARM.
- Run is combinational: (state == RUN) & ~Halt. It is 0 in every other state.
- Flags: in RUN with FlagWrite = 1 and Halt = 0, ZeroFlag <= AluZero and NegFlag <= AluNeg. Otherwise they hold.
- Branch resolution uses the registered flags, i.e. the flags from the previous flag-writing instruction, not this cycle's ALU outputs.
  - cond = (BranchFlag ? NegFlag : ZeroFlag) ^ BranchInvert.
- Next PC in RUN, in priority order:
  1. Halt or PC == LAST_ADDR: hold.
  2. AbsBranch & cond: AbsTarget.
  3. RelBranch & cond: PC + sign_extend(RelOffset), modulo 2^PC_W; wraps in both directions.
  4. Otherwise: PC + 1, modulo 2^PC_W.
- AbsBranch and RelBranch both high is not produced by the decoder; absolute wins.
- A branch whose target equals LAST_ADDR is legal. The program ends after that instruction executes.
- CycleCount:
  - Increments once per RUN cycle, including the halt cycle.
  - Saturates at all-ones; no wrap.
  - Holds in DONE; cleared in ARM and on Reset.
- Start asserted and released in the same cycle as Reset: Reset wins; the sequencer stays in IDLE.

Test Plan:
1. Reset high 2 cycles; Start 1 for 3 cycles then 0; straight-line code, no branches -> PC = 0 for the 3 ARM cycles, then 1, 2, 3 each cycle; Run = 1 from the first RUN cycle; CycleCount tracks.
2. FlagWrite = 1 with AluZero = 1 at PC = 4; at PC = 5 RelBranch = 1, BranchFlag = 0, BranchInvert = 0, RelOffset = 6'b111101 (-3) -> next PC = 2. Repeat with BranchInvert = 1 -> next PC = 6.
3. NegFlag = 1 from a prior instruction; AbsBranch = 1, BranchFlag = 1, AbsTarget = 10'h3F0 -> next PC = 0x3F0. Same cycle with AluNeg = 0 and FlagWrite = 1 -> branch still taken, NegFlag becomes 0 the next cycle.
4. Halt = 1 at PC = 7 -> Run = 0 that cycle; Done = 1 the next cycle; PC stays 7; Start pulse then returns PC to 0 and clears Done on the ARM entry.
5. Run reaches LAST_ADDR = 1023 (also: RelOffset = +1 at PC = 1022, taken) -> the instruction at 1023 executes with Run = 1; Done = 1 the following cycle; PC holds 1023, with no wrap to 0.
6. Reset asserted mid-RUN at PC = 12 with CycleCount = 12 -> next cycle PC = 0, CycleCount = 0, flags 0, Done = 0, Run = 0, state IDLE. Separately, force 2^CNT_W + 5 RUN cycles -> CycleCount stays 16'hFFFF.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-flow controller for the 9-bit core: owns the PC, the Start/Done
// handshake with the harness, the zero/negative flags and a saturating cycle counter.
module pc_sequencer #(
  parameter int PC_W      = 10,
  parameter int LAST_ADDR = 1023,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             AbsBranch,
  input  logic             RelBranch,
  input  logic             BranchFlag,
  input  logic             BranchInvert,
  input  logic [PC_W-1:0]  AbsTarget,
  input  logic [5:0]       RelOffset,
  input  logic             FlagWrite,
  input  logic             AluZero,
  input  logic             AluNeg,
  output logic [PC_W-1:0]  PC,
  output logic             Run,
  output logic             Done,
  output logic             ZeroFlag,
  output logic             NegFlag,
  output logic [CNT_W-1:0] CycleCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [PC_W-1:0]  r_pc;
  logic             r_done;
  logic             r_zero;
  logic             r_neg;
  logic [CNT_W-1:0] r_cnt;

  logic             w_cond;
  logic             w_at_last;
  logic [PC_W-1:0]  w_rel_ext;
  logic [PC_W-1:0]  w_pc_next;

  // Branch condition is taken from the registered flags, never the live ALU outputs.
  always_comb begin
    w_cond    = (BranchFlag ? r_neg : r_zero) ^ BranchInvert;
    w_at_last = (r_pc == PC_W'(LAST_ADDR));
    w_rel_ext = {{(PC_W-6){RelOffset[5]}}, RelOffset};
    w_pc_next = r_pc + PC_W'(1);
    if (AbsBranch && w_cond) begin
      w_pc_next = AbsTarget;
    end else if (RelBranch && w_cond) begin
      w_pc_next = r_pc + w_rel_ext;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_done  <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_state <= S_ARM;
          end
        end
        S_ARM: begin
          r_pc   <= '0;
          r_done <= 1'b0;
          r_zero <= 1'b0;
          r_neg  <= 1'b0;
          r_cnt  <= '0;
          if (!Start) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (Halt) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            if (FlagWrite) begin
              r_zero <= AluZero;
              r_neg  <= AluNeg;
            end
            // The last instruction still completes; only the PC is frozen.
            if (w_at_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_pc <= w_pc_next;
            end
          end
        end
        S_DONE: begin
          // Clear on the way into ARM so Done drops on ARM entry.
          if (Start) begin
            r_state <= S_ARM;
            r_pc    <= '0;
            r_done  <= 1'b0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
            r_cnt   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign PC         = r_pc;
  assign Run        = (r_state == S_RUN) && !Halt;
  assign Done       = r_done;
  assign ZeroFlag   = r_zero;
  assign NegFlag    = r_neg;
  assign CycleCount = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_pc_sequencer;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        Halt;
  logic        AbsBranch;
  logic        RelBranch;
  logic        BranchFlag;
  logic        BranchInvert;
  logic [9:0]  AbsTarget;
  logic [5:0]  RelOffset;
  logic        FlagWrite;
  logic        AluZero;
  logic        AluNeg;
  logic [9:0]  PC;
  logic        Run;
  logic        Done;
  logic        ZeroFlag;
  logic        NegFlag;
  logic [15:0] CycleCount;

  pc_sequencer #(.PC_W(10), .LAST_ADDR(1023), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
    .AbsBranch(AbsBranch), .RelBranch(RelBranch), .BranchFlag(BranchFlag),
    .BranchInvert(BranchInvert), .AbsTarget(AbsTarget), .RelOffset(RelOffset),
    .FlagWrite(FlagWrite), .AluZero(AluZero), .AluNeg(AluNeg),
    .PC(PC), .Run(Run), .Done(Done), .ZeroFlag(ZeroFlag), .NegFlag(NegFlag),
    .CycleCount(CycleCount)
  );

  typedef struct {
    string       nm;
    bit          chk;
    logic [9:0]  pc;
    logic        run;
    logic        done;
    logic        z;
    logic        n;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          n_checks++;
          if (PC === e.pc && Run === e.run && Done === e.done &&
              ZeroFlag === e.z && NegFlag === e.n && CycleCount === e.cnt) begin
            n_pass++;
          end else begin
            $display("FAIL %s: got pc=%h run=%b done=%b z=%b n=%b cnt=%h, want pc=%h run=%b done=%b z=%b n=%b cnt=%h",
                     e.nm, PC, Run, Done, ZeroFlag, NegFlag, CycleCount,
                     e.pc, e.run, e.done, e.z, e.n, e.cnt);
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge Clk);
    #1;
    Start = 0; Halt = 0; AbsBranch = 0; RelBranch = 0; BranchFlag = 0;
    BranchInvert = 0; AbsTarget = '0; RelOffset = '0; FlagWrite = 0;
    AluZero = 0; AluNeg = 0;
  endtask

  task automatic exp_push(input string nm, input bit chk, input logic [9:0] pc,
                          input logic run, input logic done, input logic z,
                          input logic n, input logic [15:0] cnt);
    exp_t e;
    e.nm = nm; e.chk = chk; e.pc = pc; e.run = run; e.done = done;
    e.z = z; e.n = n; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic rel(input logic f, input logic inv, input logic [5:0] off);
    RelBranch = 1; BranchFlag = f; BranchInvert = inv; RelOffset = off;
  endtask

  task automatic absb(input logic f, input logic inv, input logic [9:0] tgt);
    AbsBranch = 1; BranchFlag = f; BranchInvert = inv; AbsTarget = tgt;
  endtask

  task automatic fw(input logic z, input logic n);
    FlagWrite = 1; AluZero = z; AluNeg = n;
  endtask

  initial begin
    Reset = 1;
    Start = 0; Halt = 0; AbsBranch = 0; RelBranch = 0; BranchFlag = 0;
    BranchInvert = 0; AbsTarget = '0; RelOffset = '0; FlagWrite = 0;
    AluZero = 0; AluNeg = 0;

    // Reset, with a Start pulse swallowed by reset
    next_cycle(); exp_push("rst_a", 1, 0, 0, 0, 0, 0, 0);
    next_cycle(); Start = 1; exp_push("rst_b", 1, 0, 0, 0, 0, 0, 0);
    next_cycle(); Reset = 0; exp_push("rst_start", 1, 0, 0, 0, 0, 0, 0);
    next_cycle(); Start = 1; exp_push("idle_hold", 1, 0, 0, 0, 0, 0, 0);
    next_cycle(); Start = 1; exp_push("arm1", 1, 0, 0, 0, 0, 0, 0);
    next_cycle(); Start = 1; exp_push("arm2", 1, 0, 0, 0, 0, 0, 0);
    next_cycle(); exp_push("arm3", 1, 0, 0, 0, 0, 0, 0);

    // Straight-line code
    for (int i = 0; i < 4; i++) begin
      next_cycle(); exp_push("straight", 1, 10'(i), 1, 0, 0, 0, 16'(i));
    end
    next_cycle(); fw(1, 0); exp_push("pc4_fw", 1, 4, 1, 0, 0, 0, 4);
    next_cycle(); rel(0, 0, 6'b111101); exp_push("pc5_rel", 1, 5, 1, 0, 1, 0, 5);
    next_cycle(); exp_push("rel_back", 1, 2, 1, 0, 1, 0, 6);
    next_cycle(); exp_push("pc3", 1, 3, 1, 0, 1, 0, 7);
    next_cycle(); exp_push("pc4", 1, 4, 1, 0, 1, 0, 8);
    next_cycle(); rel(0, 1, 6'b111101); exp_push("pc5_relinv", 1, 5, 1, 0, 1, 0, 9);
    next_cycle(); fw(0, 1); exp_push("rel_inv_fall", 1, 6, 1, 0, 1, 0, 10);

    // Absolute branch on the registered flag while the ALU clears it
    next_cycle(); absb(1, 0, 10'h3F0); fw(0, 0); exp_push("pc7_abs", 1, 7, 1, 0, 0, 1, 11);
    next_cycle(); absb(1, 0, 10'h100); exp_push("abs_taken", 1, 10'h3F0, 1, 0, 0, 0, 12);
    next_cycle(); rel(0, 1, 6'b001111); exp_push("abs_not_taken", 1, 10'h3F1, 1, 0, 0, 0, 13);
    next_cycle(); rel(0, 1, 6'b111110); exp_push("wrap_fwd", 1, 0, 1, 0, 0, 0, 14);
    next_cycle(); rel(1, 1, 6'b000001); exp_push("wrap_back", 1, 10'h3FE, 1, 0, 0, 0, 15);

    // Last address: executes, flags update, PC frozen
    next_cycle(); absb(0, 1, 10'h005); fw(1, 1); exp_push("last_addr", 1, 10'h3FF, 1, 0, 0, 0, 16);
    next_cycle(); absb(0, 1, 10'h005); fw(0, 0); exp_push("last_done", 1, 10'h3FF, 0, 1, 1, 1, 17);
    next_cycle(); Start = 1; exp_push("done_hold", 1, 10'h3FF, 0, 1, 1, 1, 17);
    next_cycle(); exp_push("rearm", 1, 0, 0, 0, 0, 0, 0);

    // Halt at PC 7
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      if (i == 2) fw(0, 1);
      exp_push("run2", 1, 10'(i), 1, 0, 0, (i > 2), 16'(i));
    end
    next_cycle(); Halt = 1; fw(1, 0); absb(1, 0, 10'h3F0);
    exp_push("halt", 1, 7, 0, 0, 0, 1, 7);
    next_cycle(); exp_push("halt_done", 1, 7, 0, 1, 0, 1, 8);
    next_cycle(); Start = 1; exp_push("done_start", 1, 7, 0, 1, 0, 1, 8);
    next_cycle(); exp_push("arm_again", 1, 0, 0, 0, 0, 0, 0);

    // Reset mid-RUN at PC 12
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      if (i == 5) fw(1, 0);
      exp_push("run3", 1, 10'(i), 1, 0, (i > 5), 0, 16'(i));
    end
    next_cycle(); Reset = 1; exp_push("pc12", 1, 12, 1, 0, 1, 0, 12);
    next_cycle(); Reset = 0; exp_push("after_rst", 1, 0, 0, 0, 0, 0, 0);
    next_cycle(); Start = 1; exp_push("idle2", 1, 0, 0, 0, 0, 0, 0);
    next_cycle(); exp_push("arm_sat", 1, 0, 0, 0, 0, 0, 0);

    // Counter saturation: spin on PC 0 with a taken zero-offset branch
    for (int i = 0; i < 65541; i++) begin
      logic [15:0] c;
      c = (i >= 65535) ? 16'hFFFF : 16'(i);
      next_cycle(); rel(0, 1, 6'b000000);
      exp_push("sat", (i < 2) || (i >= 65533), 0, 1, 0, 0, 0, c);
    end
    next_cycle(); Halt = 1; exp_push("sat_halt", 1, 0, 0, 0, 0, 0, 16'hFFFF);
    next_cycle(); exp_push("sat_done", 1, 0, 0, 1, 0, 0, 16'hFFFF);

    // Bounded drain of the scoreboard
    for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge Clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
